// File: rtl/acct_pkg.sv
// Shared defaults and types for the account frame arbiter.
package acct_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int FRAME_DEF = 5;

  typedef enum logic {ARB, XFER} state_e;

  typedef struct packed {
    logic [DSIZE_DEF-1:0] account;
    logic [DSIZE_DEF-1:0] a;
    logic [DSIZE_DEF-1:0] t;
  } rec_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one search over req_valid, starting at ptr.
module rr_pick
  import acct_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [SW-1:0]   ptr,
  output logic            hit,
  output logic [SW-1:0]   idx
);

  logic [SW-1:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = ptr;
    cand = ptr;
    // Walk offsets high to low so the nearest requester at or above ptr is the last writer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SW'(k);
      if (req_valid[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/acct_frame_arbiter.sv
// Round-robin frame arbiter: grants the shared window datapath to one requester for a whole
// frame of FRAME records, abandoning the frame after TIMEOUT idle cycles of the owner.
module acct_frame_arbiter
  import acct_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int NREQ    = 4,
  parameter int FRAME   = FRAME_DEF,
  parameter int TIMEOUT = 16,
  parameter int SW      = $clog2(NREQ)
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DSIZE-1:0] req_account,
  input  logic [NREQ*DSIZE-1:0] req_A,
  input  logic [NREQ*DSIZE-1:0] req_T,
  output logic                  ds_valid,
  input  logic                  ds_ready,
  output logic [DSIZE-1:0]      ds_account,
  output logic [DSIZE-1:0]      ds_A,
  output logic [DSIZE-1:0]      ds_T,
  output logic [SW-1:0]         ds_src,
  output logic                  ds_last,
  output logic                  ds_abort
);

  localparam int FW = $clog2(FRAME + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FcntLast = FW'(FRAME - 1);
  localparam logic [IW-1:0] IcntLast = IW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    owner_q, owner_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [IW-1:0]    icnt_q, icnt_d;
  logic             ds_valid_q, ds_valid_d;
  logic [DSIZE-1:0] ds_account_q, ds_account_d;
  logic [DSIZE-1:0] ds_a_q, ds_a_d;
  logic [DSIZE-1:0] ds_t_q, ds_t_d;
  logic [SW-1:0]    ds_src_q, ds_src_d;
  logic             ds_last_q, ds_last_d;
  logic             ds_abort_q, ds_abort_d;

  logic             pick_hit;
  logic [SW-1:0]    pick_idx;
  logic             own_valid;
  logic             own_rdy;
  logic             xfer;

  rr_pick #(
    .NREQ(NREQ),
    .SW  (SW)
  ) u_rr_pick (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .hit      (pick_hit),
    .idx      (pick_idx)
  );

  assign own_valid = req_valid[owner_q];
  assign own_rdy   = (state_q == XFER) && (!ds_valid_q || ds_ready);
  assign xfer      = own_valid && own_rdy;

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = own_rdy;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    fcnt_d     = fcnt_q;
    icnt_d     = icnt_q;
    ds_abort_d = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_hit) begin
          owner_d = pick_idx;
          fcnt_d  = '0;
          icnt_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          fcnt_d = fcnt_q + FW'(1);
          icnt_d = '0;
          if (fcnt_q == FcntLast) begin
            ptr_d   = owner_q + SW'(1);
            state_d = ARB;
          end
        end else if (!own_valid) begin
          if (icnt_q == IcntLast) begin
            ds_abort_d = 1'b1;
            ptr_d      = owner_q + SW'(1);
            state_d    = ARB;
          end else begin
            icnt_d = icnt_q + IW'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Output register: drains on ds_ready, reloads on any owner transfer (both may coincide).
  always_comb begin
    ds_valid_d   = ds_valid_q && !ds_ready;
    ds_account_d = ds_account_q;
    ds_a_d       = ds_a_q;
    ds_t_d       = ds_t_q;
    ds_src_d     = ds_src_q;
    ds_last_d    = ds_last_q;
    if (xfer) begin
      ds_valid_d   = 1'b1;
      ds_account_d = req_account[owner_q*DSIZE +: DSIZE];
      ds_a_d       = req_A[owner_q*DSIZE +: DSIZE];
      ds_t_d       = req_T[owner_q*DSIZE +: DSIZE];
      ds_src_d     = owner_q;
      ds_last_d    = (fcnt_q == FcntLast);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      owner_q      <= '0;
      fcnt_q       <= '0;
      icnt_q       <= '0;
      ds_valid_q   <= 1'b0;
      ds_account_q <= '0;
      ds_a_q       <= '0;
      ds_t_q       <= '0;
      ds_src_q     <= '0;
      ds_last_q    <= 1'b0;
      ds_abort_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      fcnt_q       <= fcnt_d;
      icnt_q       <= icnt_d;
      ds_valid_q   <= ds_valid_d;
      ds_account_q <= ds_account_d;
      ds_a_q       <= ds_a_d;
      ds_t_q       <= ds_t_d;
      ds_src_q     <= ds_src_d;
      ds_last_q    <= ds_last_d;
      ds_abort_q   <= ds_abort_d;
    end
  end

  assign ds_valid   = ds_valid_q;
  assign ds_account = ds_account_q;
  assign ds_A       = ds_a_q;
  assign ds_T       = ds_t_q;
  assign ds_src     = ds_src_q;
  assign ds_last    = ds_last_q;
  assign ds_abort   = ds_abort_q;

endmodule

// File: tb/tb_acct_frame_arbiter.sv
// Scoreboard bench for acct_frame_arbiter: a frame-level reference model predicts each
// forwarded record; a separate monitor compares whatever the DUT presents.
module tb_acct_frame_arbiter;
  import acct_pkg::*;

  localparam int NREQ = 4;
  localparam int DS   = 8;
  localparam int FRM  = 5;
  localparam int TMO  = 16;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DS-1:0] req_account = '0;
  logic [NREQ*DS-1:0] req_A = '0;
  logic [NREQ*DS-1:0] req_T = '0;
  logic              ds_valid;
  logic              ds_ready = 1'b0;
  logic [DS-1:0]     ds_account;
  logic [DS-1:0]     ds_A;
  logic [DS-1:0]     ds_T;
  logic [1:0]        ds_src;
  logic              ds_last;
  logic              ds_abort;

  typedef struct packed {
    rec_t       rec;
    logic [1:0] src;
    logic       last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   seq[NREQ];
  int   hs_cnt[NREQ];

  // Reference model: arbitrating (m_arb) or serving m_owner; m_cnt records sent, m_idle idle cycles.
  bit m_arb = 1'b1;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_idle = 0;
  bit m_full = 1'b0;
  bit m_abort = 1'b0;

  acct_frame_arbiter #(
    .DSIZE  (DS),
    .NREQ   (NREQ),
    .FRAME  (FRM),
    .TIMEOUT(TMO),
    .SW     (2)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_account(req_account),
    .req_A      (req_A),
    .req_T      (req_T),
    .ds_valid   (ds_valid),
    .ds_ready   (ds_ready),
    .ds_account (ds_account),
    .ds_A       (ds_A),
    .ds_T       (ds_T),
    .ds_src     (ds_src),
    .ds_last    (ds_last),
    .ds_abort   (ds_abort)
  );

  always #5 clk1 = ~clk1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void drive_data(int i);
    req_account[i*DS +: DS] = 8'(seq[i]);
    req_A[i*DS +: DS]       = 8'($urandom);
    req_T[i*DS +: DS]       = 8'($urandom);
  endfunction

  // Model: advances once per rising edge using the inputs the DUT samples at that edge.
  initial begin : model
    bit   load;
    bit   abort_n;
    exp_t e;
    forever begin
      @(posedge clk1);
      if (rst) begin
        m_arb = 1'b1; m_ptr = 0; m_cnt = 0; m_idle = 0; m_full = 1'b0; m_abort = 1'b0;
        sbq.delete();
      end else begin
        load = 1'b0;
        abort_n = 1'b0;
        if (m_arb) begin
          for (int k = 0; k < NREQ; k++) begin
            if (m_arb && req_valid[(m_ptr + k) % NREQ]) begin
              m_owner = (m_ptr + k) % NREQ;
              m_cnt = 0;
              m_idle = 0;
              m_arb = 1'b0;
            end
          end
        end else if (req_valid[m_owner] && (!m_full || ds_ready)) begin
          e.rec.account = req_account[m_owner*DS +: DS];
          e.rec.a       = req_A[m_owner*DS +: DS];
          e.rec.t       = req_T[m_owner*DS +: DS];
          e.src         = 2'(m_owner);
          e.last        = (m_cnt == FRM - 1);
          sbq.push_back(e);
          load = 1'b1;
          m_cnt++;
          m_idle = 0;
          if (m_cnt == FRM) begin
            m_ptr = (m_owner + 1) % NREQ;
            m_arb = 1'b1;
          end
        end else if (!req_valid[m_owner]) begin
          m_idle++;
          if (m_idle == TMO) begin
            abort_n = 1'b1;
            m_ptr = (m_owner + 1) % NREQ;
            m_arb = 1'b1;
          end
        end
        m_full  = load || (m_full && !ds_ready);
        m_abort = abort_n;
      end
    end
  end

  // Monitor: compares presented outputs on the falling edge; pops a record when it is taken.
  initial begin : monitor
    logic [NREQ-1:0] er;
    forever begin
      @(negedge clk1);
      er = '0;
      if (!m_arb && (!m_full || ds_ready)) er[m_owner] = 1'b1;
      check("req_ready", req_ready, er);
      check("ds_valid", ds_valid, m_full);
      check("ds_abort", ds_abort, m_abort);
      if (ds_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL ds_record: got valid record, expected none at %0t", $time);
        end else begin
          check("ds_record", {ds_account, ds_A, ds_T, ds_src, ds_last}, sbq[0]);
          if (ds_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic step();
    logic [NREQ-1:0] hs;
    @(negedge clk1);
    hs = req_valid & req_ready;
    @(posedge clk1);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        hs_cnt[i]++;
        seq[i] = seq[i] + 1;
        drive_data(i);
      end
    end
  endtask

  task automatic wait_hs(int i, int n, string nm);
    int b = 0;
    while (hs_cnt[i] < n && b < 200) begin
      step();
      b++;
    end
    checks++;
    if (hs_cnt[i] >= n) passes++;
    else $display("FAIL %s: got %0d transfers, expected %0d within budget", nm, hs_cnt[i], n);
  endtask

  initial begin : stim
    int obs_acc[$];
    int obs_last[$];
    int obs_src[$];
    int base;
    int aborts;
    int first_src;
    int prob[NREQ];

    for (int i = 0; i < NREQ; i++) begin
      seq[i] = i * 50;
      hs_cnt[i] = 0;
      drive_data(i);
    end

    // Reset held two cycles with requesters valid.
    rst = 1'b1; req_valid = '1; ds_ready = 1'b1;
    step(); step();
    check("rst ds_valid", ds_valid, 0);
    check("rst ds_account", ds_account, 0);
    check("rst ds_A", ds_A, 0);
    check("rst ds_T", ds_T, 0);
    check("rst ds_src", ds_src, 0);
    check("rst ds_last", ds_last, 0);
    check("rst ds_abort", ds_abort, 0);
    check("rst req_ready", req_ready, 0);

    // Single requester 2, accounts 10..14, then 1-cycle gap.
    req_valid = 4'b0100; seq[2] = 10; drive_data(2); rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      step();
      check("single valid pattern", ds_valid, (s != 0 && s != 6));
      if (ds_valid) begin
        obs_acc.push_back(int'(ds_account));
        obs_last.push_back(int'(ds_last));
        check("single ds_src", ds_src, 2);
      end
    end
    for (int k = 0; k < 5; k++) begin
      check("single account", obs_acc[k], 10 + k);
      check("single last", obs_last[k], (k == 4));
    end

    // Rotation with all requesters valid.
    rst = 1'b1; step(); rst = 1'b0; req_valid = '1;
    for (int s = 0; s < 32; s++) begin
      step();
      if (ds_valid) obs_src.push_back(int'(ds_src));
    end
    check("rotation count", obs_src.size() >= 25, 1);
    for (int k = 0; k < 25 && k < obs_src.size(); k++)
      check("rotation src", obs_src[k], (k / 5) % 4);

    // Backpressure after the 2nd record of a frame.
    rst = 1'b1; step(); rst = 1'b0; req_valid = 4'b0001;
    base = seq[0];
    wait_hs(0, hs_cnt[0] + 2, "bp first two");
    ds_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("bp hold account", ds_account, 8'(base + 1));
      check("bp hold valid", ds_valid, 1);
      check("bp req_ready", req_ready, 0);
    end
    ds_ready = 1'b1;
    obs_acc.delete();
    for (int s = 0; s < 6; s++) begin
      step();
      if (ds_valid) obs_acc.push_back(int'(ds_account));
    end
    for (int k = 0; k < 3; k++) check("bp resume account", obs_acc[k], (base + 2 + k) % 256);

    // Timeout: owner 1 stalls while requester 3 waits.
    rst = 1'b1; step(); rst = 1'b0; req_valid = 4'b0010;
    wait_hs(1, hs_cnt[1] + 2, "timeout first two");
    req_valid = 4'b1000;
    aborts = 0; first_src = -1;
    for (int s = 0; s < 25; s++) begin
      step();
      if (ds_abort) aborts++;
      if (aborts > 0 && ds_valid && first_src < 0) first_src = int'(ds_src);
    end
    check("timeout abort pulses", aborts, 1);
    check("timeout next owner", first_src, 3);

    // Reset in the middle of a frame.
    rst = 1'b1; step(); rst = 1'b0; req_valid = '1;
    wait_hs(0, hs_cnt[0] + 3, "midrst three");
    check("midrst pre valid", ds_valid, 1);
    rst = 1'b1; step();
    check("midrst ds_valid", ds_valid, 0);
    check("midrst ds_abort", ds_abort, 0);
    rst = 1'b0; step(); step();
    check("midrst regrant valid", ds_valid, 1);
    check("midrst regrant src", ds_src, 0);

    // Randomized traffic with varying activity and backpressure.
    for (int s = 0; s < 1500; s++) begin
      if (s % 100 == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          case ($urandom_range(3))
            0: prob[i] = 0;
            1: prob[i] = 5;
            2: prob[i] = 50;
            default: prob[i] = 100;
          endcase
        end
      end
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(99) < prob[i]);
      ds_ready = ($urandom_range(99) < 70);
      step();
    end

    req_valid = '0; ds_ready = 1'b1;
    for (int s = 0; s < 10; s++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
